seg7_scan_encoder: RTL and testbench

Reverse path for the BCD-to-7-segment decoder. Samples a time-multiplexed, one-hot-anode 7-segment bus (the form a scanned display driver emits) and confirms each digit's pattern is stable. Encodes each stable pattern back to a 4-bit code. Presents one complete multi-digit frame through a valid/ready handshake. It sits at the display-bus tap point and feeds self-checking logic or a host readback register.

---
 rtl/seg7_scan_encoder.sv | 122 ++++++++++++
 tb/tb_seg7_scan_encoder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_encoder.sv
// Samples a scanned one-hot-anode 7-segment bus, captures each digit once it is stable,
// and presents the decoded frame over valid/ready. Define SEG7_HEX_EN to accept A..F glyphs.
module seg7_scan_encoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     err_out,
  output logic                  valid,
  input  logic                  ready
);

  // Handshake: a frame transfers on a rising edge where valid && ready; valid then
  // drops on that edge and the frame contents stay frozen while valid is high.

  typedef enum logic {COLLECT = 1'b0, PRESENT = 1'b1} state_t;

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  state_t              state, state_next;
  logic [6:0]          s_seg;
  logic [DIGITS-1:0]   s_an;
  logic [7:0]          count, count_next;
  logic [DIGITS-1:0]   captured;
  logic [DIGITS-1:0]   hit;
  logic [3:0]          dec_code;
  logic                dec_err;

  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'b1_0000;
    case (seg)
      7'h7E: r = 5'h00;
      7'h30: r = 5'h01;
      7'h6D: r = 5'h02;
      7'h79: r = 5'h03;
      7'h33: r = 5'h04;
      7'h5B: r = 5'h05;
      7'h5F: r = 5'h06;
      7'h70: r = 5'h07;
      7'h7F: r = 5'h08;
      7'h7B: r = 5'h09;
`ifdef SEG7_HEX_EN
      7'h77: r = 5'h0A;
      7'h1F: r = 5'h0B;
      7'h4E: r = 5'h0C;
      7'h3D: r = 5'h0D;
      7'h4F: r = 5'h0E;
      7'h47: r = 5'h0F;
`else
`endif
      default: r = 5'b1_0000;
    endcase
    return r;
  endfunction

  // The counter tracks the value being registered this edge against the one already
  // held, so it reaches STABLE_CYCLES after that many identical registered samples.
  always_comb begin
    count_next = 8'd0;
    if (!$onehot(an_in))
      count_next = 8'd0;
    else if (seg_in == s_seg && an_in == s_an)
      count_next = (count >= STABLE) ? STABLE : count + 8'd1;
    else
      count_next = 8'd1;
  end

  always_comb begin
    {dec_err, dec_code} = decode(s_seg);
    hit = '0;
    if (state == COLLECT && count == STABLE)
      hit = s_an & ~captured;
  end

  // State register plus the datapath it governs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= COLLECT;
      s_seg    <= '0;
      s_an     <= '0;
      count    <= '0;
      captured <= '0;
      bcd_out  <= '0;
      err_out  <= '0;
    end else begin
      state <= state_next;
      s_seg <= seg_in;
      s_an  <= an_in;
      count <= count_next;
      if (state == COLLECT) begin
        captured <= captured | hit;
        for (int i = 0; i < DIGITS; i++) begin
          if (hit[i]) begin
            bcd_out[4*i +: 4] <= dec_code;
            err_out[i]        <= dec_err;
          end
        end
      end else if (ready) begin
        captured <= '0;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (&captured) state_next = PRESENT;
      PRESENT: if (ready)     state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_comb begin
    valid = (state == PRESENT);
  end

endmodule

// File: tb/tb_seg7_scan_encoder.sv
// Directed bench for seg7_scan_encoder (DIGITS=4, STABLE_CYCLES=4); frame expectations
// go into a queue that a monitor drains each time valid rises.
module tb_seg7_scan_encoder;

  localparam int D = 4;

  logic           clk;
  logic           reset;
  logic [6:0]     seg_in;
  logic [D-1:0]   an_in;
  logic [4*D-1:0] bcd_out;
  logic [D-1:0]   err_out;
  logic           valid;
  logic           ready;

  logic [5*D-1:0] exp_q[$];
  int             n_cmp;
  int             n_err;
  logic           valid_d;

  seg7_scan_encoder #(.DIGITS(D), .STABLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .an_in(an_in),
    .bcd_out(bcd_out), .err_out(err_out), .valid(valid), .ready(ready)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: called at a negedge, holds the bus for n rising edges
  task automatic hold(input logic [6:0] s, input logic [3:0] a, input int n);
    seg_in = s;
    an_in  = a;
    repeat (n) @(negedge clk);
  endtask

  // monitor / scoreboard
  initial valid_d = 1'b0;
  always @(negedge clk) begin
    if (valid && !valid_d) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'd1, 32'd0);
      end else begin
        logic [5*D-1:0] e;
        e = exp_q.pop_front();
        check("frame_bcd", 32'(bcd_out), 32'(e[5*D-1:D]));
        check("frame_err", 32'(err_out), 32'(e[D-1:0]));
      end
    end
    valid_d = valid;
  end

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    reset  = 1'b0;
    seg_in = 7'h00;
    an_in  = '0;
    ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_bcd", 32'(bcd_out), 32'h0);
    check("reset_err", 32'(err_out), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    reset = 1'b1;

    // frame 1: digits 1,2,3,4
    exp_q.push_back({16'h4321, 4'b0000});
    hold(7'h30, 4'b0001, 6);
    hold(7'h6D, 4'b0010, 6);
    hold(7'h79, 4'b0100, 6);
    hold(7'h33, 4'b1000, 5);
    check("valid_early", 32'(valid), 32'h0);
    hold(7'h33, 4'b1000, 1);
    check("valid_rise", 32'(valid), 32'h1);

    // back-pressure: 20 cycles of new traffic must not disturb the frame
    hold(7'h77, 4'b0100, 8);
    hold(7'h7F, 4'b0010, 4);
    hold(7'h5F, 4'b0010, 8);
    check("freeze_valid", 32'(valid), 32'h1);
    check("freeze_bcd", 32'(bcd_out), 32'h4321);
    check("freeze_err", 32'(err_out), 32'h0);

    // accept; digit 1 is already stable and captures on the first COLLECT cycle
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("accept_valid", 32'(valid), 32'h0);
    check("accept_bcd_hold", 32'(bcd_out), 32'h4321);
    @(negedge clk);
    check("first_collect_capture", 32'(bcd_out), 32'h4361);

    // frame 2
`ifdef SEG7_HEX_EN
    exp_q.push_back({16'h5A69, 4'b0000});
`else
    exp_q.push_back({16'h5069, 4'b0100});
`endif
    hold(7'h7E, 4'b0011, 10);
    check("multi_an_bcd", 32'(bcd_out), 32'h4361);
    check("multi_an_err", 32'(err_out), 32'h0);
    check("multi_an_valid", 32'(valid), 32'h0);
    hold(7'h7E, 4'b0000, 10);
    check("zero_an_bcd", 32'(bcd_out), 32'h4361);
    check("zero_an_valid", 32'(valid), 32'h0);
    hold(7'h7F, 4'b0001, 3);
    hold(7'h7B, 4'b0001, 4);
    hold(7'h00, 4'b0000, 1);
    check("glitch_nibble0", 32'(bcd_out), 32'h4369);
    hold(7'h77, 4'b0100, 6);
    hold(7'h5B, 4'b1000, 6);
    hold(7'h00, 4'b0000, 2);
    check("f2_valid", 32'(valid), 32'h1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("f2_accept_valid", 32'(valid), 32'h0);

    // reset after two captures discards the partial frame
    hold(7'h7E, 4'b0001, 6);
    hold(7'h30, 4'b0010, 6);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_bcd", 32'(bcd_out), 32'h0);
    check("midreset_err", 32'(err_out), 32'h0);
    check("midreset_valid", 32'(valid), 32'h0);
    reset = 1'b1;

    // frame 3 after reset: all digits must be collected again
    exp_q.push_back({16'h8888, 4'b0000});
    hold(7'h7F, 4'b0001, 6);
    hold(7'h7F, 4'b0010, 6);
    hold(7'h7F, 4'b0100, 6);
    hold(7'h7F, 4'b1000, 1);
    check("f3_not_early", 32'(valid), 32'h0);
    for (int i = 0; i < 40 && !valid; i++) @(negedge clk);
    check("f3_valid", 32'(valid), 32'h1);
    @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
